// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default
// latencies, counter width and the packed {hi,lo} result type.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_res_t;

    function automatic logic is_arith(mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div(mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage issue bus into the MDU plus the HI/LO/busy status coming back.
interface mdu_if;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, mdu_op, a, b, input busy, hi, lo);
    modport slave  (input start, mdu_op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_calc.sv
// Combinational mult/multu/div/divu result generator with the divide-by-zero
// flag; the result is latched by mdu_unit at issue time.
module mdu_calc
    import mdu_pkg::*;
(
    input  mdu_op_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output mdu_res_t    res,
    output logic        div_zero
);

    logic signed [63:0] sprod;
    logic        [63:0] uprod;
    logic        [31:0] b_safe;
    logic        [31:0] uq, ur;
    logic signed [31:0] sq, sr;
    logic               b_zero, ovf;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    assign b_zero   = (b == 32'd0);
    assign ovf      = (op == MDU_DIV) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign div_zero = b_zero && is_div(op);

    // Dividing by 1 in the overflow case yields exactly lo=0x80000000, hi=0,
    // and keeps the divider away from the undefined INT_MIN/-1 case.
    assign b_safe = (b_zero || ovf) ? 32'd1 : b;

    assign sq = $signed(a) / $signed(b_safe);
    assign sr = $signed(a) % $signed(b_safe);
    assign uq = a / b_safe;
    assign ur = a % b_safe;

    always_comb begin
        res = '0;
        case (op)
            MDU_MULT:  res = sprod;
            MDU_MULTU: res = uprod;
            MDU_DIV:   res = {sr, sq};
            MDU_DIVU:  res = {ur, uq};
            default:   res = '0;
        endcase
    end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Optional busy-cycle
// performance counter enabled with `define MDU_PERF_CNT_EN.
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    mdu_if.slave        bus
`ifdef MDU_PERF_CNT_EN
    ,
    output logic [31:0] busy_cycles
`endif
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               busy_q;
    logic [31:0]        hi_q, lo_q;
    mdu_res_t           pend;
    logic               pend_zero;

    mdu_op_e            op;
    mdu_res_t           calc_res;
    logic               calc_zero;

    assign op = mdu_op_e'(bus.mdu_op);

    mdu_calc u_calc (
        .op       (op),
        .a        (bus.a),
        .b        (bus.b),
        .res      (calc_res),
        .div_zero (calc_zero)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend      <= '0;
            pend_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && is_arith(op)) begin
                        pend      <= calc_res;
                        pend_zero <= calc_zero;
                        cnt       <= is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        busy_q    <= 1'b1;
                        state     <= RUN;
                    end else if (op == MDU_MTHI) begin
                        hi_q <= bus.a;
                    end else if (op == MDU_MTLO) begin
                        lo_q <= bus.a;
                    end
                end
                RUN: begin
                    // Issue and moves are dropped here; the hazard unit keeps them out.
                    if (cnt == CNT_W'(1)) begin
                        if (!pend_zero) begin
                            hi_q <= pend.hi;
                            lo_q <= pend.lo;
                        end
                        busy_q <= 1'b0;
                        cnt    <= '0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

`ifdef MDU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) busy_cycles <= '0;
        else if (busy_q) busy_cycles <= busy_cycles + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected {hi,lo,cycles} queued at issue,
// popped and compared when busy falls.
module tb_mdu_unit;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    mdu_if mdu ();
`ifdef MDU_PERF_CNT_EN
    logic [31:0] busy_cycles;
`endif

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mdu)
`ifdef MDU_PERF_CNT_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi, m_lo;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic issue(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input int cyc);
        exp_t e;
        @(negedge clk);
        mdu.start = 1'b1; mdu.mdu_op = op; mdu.a = a; mdu.b = b;
        e.hi = ehi; e.lo = elo; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Count busy cycles, optionally inject ignored traffic, then compare.
    task automatic drain(input bit intrude);
        exp_t e;
        int   n;
        e = sb.pop_front();
        n = 0;
        @(negedge clk);
        mdu.start = 1'b0; mdu.mdu_op = 3'd0; mdu.a = $urandom; mdu.b = $urandom;
        chk("hold_hi", mdu.hi, m_hi);
        chk("hold_lo", mdu.lo, m_lo);
        while (mdu.busy && n < 40) begin
            n++;
            if (intrude) begin
                case (n)
                    2: begin mdu.start = 1'b1; mdu.mdu_op = MDU_DIV; mdu.a = 32'd100; mdu.b = 32'd7; end
                    3: begin mdu.start = 1'b0; mdu.mdu_op = MDU_MTHI; mdu.a = 32'hDEAD_BEEF; end
                    4: begin mdu.mdu_op = MDU_MTLO; mdu.a = 32'hCAFE_F00D; end
                    default: begin mdu.start = 1'b0; mdu.mdu_op = 3'd0; end
                endcase
            end
            @(negedge clk);
        end
        mdu.start = 1'b0; mdu.mdu_op = 3'd0;
        chk("busy_cycles", n, e.cyc);
        chk("res_hi", mdu.hi, e.hi);
        chk("res_lo", mdu.lo, e.lo);
        m_hi = e.hi; m_lo = e.lo;
    endtask

    task automatic move(input mdu_op_e op, input logic [31:0] a);
        @(negedge clk);
        mdu.start = 1'b0; mdu.mdu_op = op; mdu.a = a;
        @(negedge clk);
        mdu.mdu_op = 3'd0;
        if (op == MDU_MTHI) m_hi = a; else m_lo = a;
        chk("move_busy", mdu.busy, 1'b0);
        chk("move_hi", mdu.hi, m_hi);
        chk("move_lo", mdu.lo, m_lo);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rb;
        int          sa, sb_i;
        longint      sp;
        logic [63:0] up;

        mdu.start = 1'b0; mdu.mdu_op = 3'd0; mdu.a = '0; mdu.b = '0;
        m_hi = '0; m_lo = '0;
        #12;
        chk("rst_busy", mdu.busy, 1'b0);
        chk("rst_hi", mdu.hi, 32'd0);
        chk("rst_lo", mdu.lo, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        issue(MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);   drain(0);
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 5); drain(0);
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);  drain(0);
        issue(MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);                          drain(0);

        move(MDU_MTHI, 32'h1234);
        move(MDU_MTLO, 32'h5678);
        issue(MDU_DIV, 32'd99, 32'd0, 32'h1234, 32'h5678, 10);                   drain(0);
        issue(MDU_DIVU, 32'd99, 32'd0, 32'h1234, 32'h5678, 10);                  drain(0);
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10);  drain(0);
        issue(MDU_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10);          drain(0);

        for (int i = 0; i < 6; i++) begin
            ra = $urandom; rb = $urandom;
            case (i % 3)
                0: begin
                    sa = ra; sb_i = rb; sp = longint'(sa) * longint'(sb_i);
                    issue(MDU_MULT, ra, rb, sp[63:32], sp[31:0], 5);
                end
                1: begin
                    up = {32'd0, ra} * {32'd0, rb};
                    issue(MDU_MULTU, ra, rb, up[63:32], up[31:0], 5);
                end
                default: begin
                    rb = rb >> (i * 4);
                    if (rb == 0) rb = 32'd3;
                    issue(MDU_DIVU, ra, rb, ra % rb, ra / rb, 10);
                end
            endcase
            drain(0);
        end

        // Start plus moves arriving mid-operation must leave no trace.
        issue(MDU_MULT, 32'd2, 32'd3, 32'd0, 32'd6, 5); drain(1);
        repeat (3) @(negedge clk);
        chk("post_ignore_busy", mdu.busy, 1'b0);
        chk("post_ignore_hi", mdu.hi, 32'd0);
        chk("post_ignore_lo", mdu.lo, 32'd6);

        // Async reset in busy cycle 4 discards the divide.
        move(MDU_MTHI, 32'hAAAA_5555);
        issue(MDU_DIVU, 32'd100, 32'd7, 32'd0, 32'd0, 10);
        void'(sb.pop_back());
        @(negedge clk);
        mdu.start = 1'b0; mdu.mdu_op = 3'd0;
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", mdu.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", mdu.busy, 1'b0);
        chk("mid_rst_hi", mdu.hi, 32'd0);
        chk("mid_rst_lo", mdu.lo, 32'd0);
`ifdef MDU_PERF_CNT_EN
        chk("mid_rst_perf", busy_cycles, 32'd0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (15) @(negedge clk);
        chk("after_rst_busy", mdu.busy, 1'b0);
        chk("after_rst_hi", mdu.hi, 32'd0);
        chk("after_rst_lo", mdu.lo, 32'd0);

        issue(MDU_MULTU, 32'd10, 32'd20, 32'd0, 32'd200, 5); drain(0);
        issue(MDU_DIV, 32'd200, 32'd10, 32'd0, 32'd20, 10);  drain(0);
`ifdef MDU_PERF_CNT_EN
        chk("perf_cnt", busy_cycles, 32'd15);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage of the pipelined MIPS CPU. It owns the HI/LO registers.
- It executes mult, multu, div, divu, mthi and mtlo.
- It exports busy/start status so the hazard unit can stall any HI/LO-touching instruction in ID.
- It is the responder to the EX-stage issue and the producer of the MDU stall condition.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15).

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle issue strobe from EX, valid with mdu_op in 1..4.
- mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved, treated as none.
- a  input  32  forwarded rs operand.
- b  input  32  forwarded rt operand.
- busy  output  1  operation in flight.
- hi  output  32  committed HI register.
- lo  output  32  committed LO register.

Behaviour:
- Reset (async, reset_n=0): hi=0, lo=0, busy=0, counter=0, state IDLE. Takes effect immediately, including mid-operation; an in-flight result is discarded.
- State machine: IDLE and RUN.
- IDLE, start=1 with mdu_op in 1..4:
  - latch the computed result into pending_hi/pending_lo;
  - load counter with MULT_CYCLES or DIV_CYCLES;
  - go to RUN.
- RUN:
  - busy=1;
  - counter decrements each cycle;
  - when counter==1, commit pending values to hi/lo, clear busy, return to IDLE.
- Timing for start sampled at edge E0 and N cycles:
  - busy is high for exactly N cycles after E0;
  - hi/lo take the new value at the same edge busy falls;
  - an mfhi/mflo released by the hazard unit reads the new value.
- Arithmetic:
  - mult: signed 32x32 to 64 bits, hi=[63:32], lo=[31:0].
  - multu: the same, unsigned.
  - div: lo = a/b truncated toward zero, hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - Operands are captured at start; later changes on a/b have no effect.
- Divide by zero (b==0 for div/divu): the operation still occupies DIV_CYCLES busy cycles, and hi/lo are left unchanged at commit.
- div of 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
- mthi/mtlo (start not required, mdu_op 5/6, IDLE only): hi or lo is written with a at the next edge, single cycle, busy stays 0.
- Events while busy, start=1 or mdu_op 5/6: ignored. The hazard unit guarantees they do not occur. The bench checks they cause no state change.
- start=1 with mdu_op 0/5/6/7: start is ignored. For 5/6 the move is performed normally.
- Hazard contract: the hazard unit stalls an MDU instruction in ID whenever (busy | start).

Optional Feature:
- Macro: MDU_PERF_CNT_EN.
- When defined:
  - extra output busy_cycles[31:0];
  - increments every cycle busy=1, wraps at 2^32;
  - reset to 0 asynchronously.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package mdu_pkg:
  - mdu_op encodings (MDU_NONE..MDU_MTLO);
  - default MULT_CYCLES/DIV_CYCLES constants;
  - a 4-bit counter width constant.
- Sub-module mdu_calc: combinational mult/multu/div/divu result generator, including the divide-by-zero and overflow rules. The outputs are a 64-bit {hi,lo} plus a div_zero flag.
- mdu_unit holds the FSM, the counter and the HI/LO registers.

Test Plan:
- Reset, then mult with a=0xFFFFFFFE, b=3 -> busy high for 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu with a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- div with a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu with a=7, b=2 -> lo=3, hi=1.
- mthi with a=0x1234, next cycle mtlo with a=0x5678 -> hi=0x1234, lo=0x5678, busy never rises. Then div with b=0 -> 10 busy cycles, hi/lo unchanged.
- Reset mid-operation:
  - start div, assert reset_n=0 at busy cycle 4 -> busy=0, hi=lo=0 immediately, and nothing is committed after reset is released;
  - a second start during busy -> ignored, and the result matches the first op only.
- With MDU_PERF_CNT_EN: mult then div -> busy_cycles=15.
